// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
//
// Multi-cycle access controller between the MEM pipeline stage and a slow,
// word-addressed external data memory.
//
// The controller converts each pipeline byte address into a word index and
// runs a req/ack handshake with the memory. While the access is in flight it
// holds Freeze high so the upstream pipeline stalls. Load data is registered.
// It is presented with a one-cycle Read_Valid strobe in the cycle where
// Freeze drops.
//
// Optional feature macro:
//   MEM_TIMEOUT_EN  - when defined, an access that sees no Ext_Ack for
//                     TIMEOUT cycles in REQ is abandoned and reported as a
//                     fault. When undefined, REQ waits indefinitely.
//
// Parameters:
//   BASE_ADDR  byte address mapped to word 0 of the external memory
//   DEPTH      external memory depth in 32-bit words (power of two, >= 2)
//   TIMEOUT    max REQ cycles without Ext_Ack (only with MEM_TIMEOUT_EN)
//
// Ports:
//   clk         clock; all state updates on the rising edge
//   rst         synchronous, active-low reset
//   MEM_R_EN    load request from the MEM stage
//   MEM_W_EN    store request from the MEM stage (wins over MEM_R_EN)
//   Mem_Addr    byte address (ALU result)
//   Wr_Data     store data
//   Freeze      stall for the pipeline registers up to and including MEM/WB
//   Read_Data   registered load data
//   Read_Valid  one-cycle strobe: Read_Data is valid
//   Err         one-cycle strobe: the access faulted
//   Ext_Req     request to the external memory
//   Ext_We      1 = write, 0 = read
//   Ext_Addr    word index into the external memory
//   Ext_Wdata   write data to the external memory
//   Ext_Ack     single-cycle completion from the external memory
//   Ext_Rdata   read data from the external memory, valid with Ext_Ack
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'd1024,
    parameter int          DEPTH     = 64,
    parameter int          TIMEOUT   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     MEM_R_EN,
    input  logic                     MEM_W_EN,
    input  logic [31:0]              Mem_Addr,
    input  logic [31:0]              Wr_Data,
    output logic                     Freeze,
    output logic [31:0]              Read_Data,
    output logic                     Read_Valid,
    output logic                     Err,
    output logic                     Ext_Req,
    output logic                     Ext_We,
    output logic [$clog2(DEPTH)-1:0] Ext_Addr,
    output logic [31:0]              Ext_Wdata,
    input  logic                     Ext_Ack,
    input  logic [31:0]              Ext_Rdata
);

    localparam int AW = $clog2(DEPTH);

    // Reject configurations the address decode cannot represent.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
        $error("mem_access_ctrl: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    // Set when the access now completing must be reported through Err.
    logic fault_q;

    // -----------------------------------------------------------------------
    // Address decode
    // -----------------------------------------------------------------------
    // The subtraction wraps for addresses below BASE_ADDR, so the lower bound
    // is checked separately instead of relying on the index compare.
    logic [31:0] word_idx;
    logic        in_range;
    logic        access_req;

    assign word_idx   = (Mem_Addr - BASE_ADDR) >> 2;
    assign in_range   = (Mem_Addr >= BASE_ADDR) && (word_idx < 32'(DEPTH));
    assign access_req = MEM_R_EN | MEM_W_EN;

    // -----------------------------------------------------------------------
    // Optional REQ watchdog
    // -----------------------------------------------------------------------
    logic expired;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] tmo_q;

    // The counter reads k-1 in the k-th REQ cycle. Expiry therefore falls on
    // the TIMEOUT-th cycle, and Ext_Req has been high for exactly TIMEOUT
    // cycles when the controller gives up.
    assign expired = (state_q == REQ) && (tmo_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            tmo_q <= '0;
        end else if (state_q == REQ) begin
            tmo_q <= tmo_q + 1'b1;
        end else begin
            tmo_q <= '0;
        end
    end
`else
    assign expired = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Next-state and Freeze
    // -----------------------------------------------------------------------
    // NOTE: every signal driven here gets a default before the case; a path
    // that left one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        Freeze  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (access_req) begin
                    Freeze  = 1'b1;
                    state_d = in_range ? REQ : DONE;
                end
            end

            REQ: begin
                Freeze = 1'b1;
                // An ack in the expiry cycle still counts as success.
                if (Ext_Ack || expired) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                // The pipeline advances at the end of this cycle. Enables
                // seen here belong to the finished access and are ignored.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every register
    // in this block samples the pre-edge values, independent of statement
    // order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            fault_q   <= 1'b0;
            Ext_We    <= 1'b0;
            Ext_Addr  <= '0;
            Ext_Wdata <= '0;
            Read_Data <= '0;
        end else begin
            state_q <= state_d;

            unique case (state_q)
                IDLE: begin
                    if (access_req) begin
                        // These are held stable for the whole REQ phase.
                        Ext_We    <= MEM_W_EN;
                        Ext_Addr  <= word_idx[AW-1:0];
                        Ext_Wdata <= Wr_Data;
                        fault_q   <= !in_range;
                        // A faulted load presents zero data in DONE.
                        if (!in_range && !MEM_W_EN) begin
                            Read_Data <= '0;
                        end
                    end
                end

                REQ: begin
                    if (Ext_Ack) begin
                        fault_q <= 1'b0;
                        if (!Ext_We) begin
                            Read_Data <= Ext_Rdata;
                        end
                    end else if (expired) begin
                        fault_q <= 1'b1;
                        if (!Ext_We) begin
                            Read_Data <= '0;
                        end
                    end
                end

                default: begin
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State-decoded outputs
    // -----------------------------------------------------------------------
    assign Ext_Req    = (state_q == REQ);
    assign Read_Valid = (state_q == DONE) && !Ext_We && !fault_q;
    assign Err        = (state_q == DONE) && fault_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Self-checking bench for mem_access_ctrl. The bench plays the role of the
// external memory (ext_mem, indexed by what the DUT drives on Ext_Addr). A
// separate reference model (ref_mem, exp_rd) predicts every outcome from the
// byte address using plain arithmetic on the address map.
// Inputs change 1 time unit after the rising edge. Outputs are sampled 1 time
// unit after that.
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;

    localparam logic [31:0] BASE    = 32'd1024;
    localparam int          DEPTH   = 64;
    localparam int          TIMEOUT = 16;
    localparam int          AW      = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst;
    logic          MEM_R_EN;
    logic          MEM_W_EN;
    logic [31:0]   Mem_Addr;
    logic [31:0]   Wr_Data;
    logic          Freeze;
    logic [31:0]   Read_Data;
    logic          Read_Valid;
    logic          Err;
    logic          Ext_Req;
    logic          Ext_We;
    logic [AW-1:0] Ext_Addr;
    logic [31:0]   Ext_Wdata;
    logic          Ext_Ack;
    logic [31:0]   Ext_Rdata;

    always #5 clk = ~clk;

    mem_access_ctrl #(
        .BASE_ADDR(BASE),
        .DEPTH    (DEPTH),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .MEM_R_EN  (MEM_R_EN),
        .MEM_W_EN  (MEM_W_EN),
        .Mem_Addr  (Mem_Addr),
        .Wr_Data   (Wr_Data),
        .Freeze    (Freeze),
        .Read_Data (Read_Data),
        .Read_Valid(Read_Valid),
        .Err       (Err),
        .Ext_Req   (Ext_Req),
        .Ext_We    (Ext_We),
        .Ext_Addr  (Ext_Addr),
        .Ext_Wdata (Ext_Wdata),
        .Ext_Ack   (Ext_Ack),
        .Ext_Rdata (Ext_Rdata)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] ext_mem [DEPTH];  // the external memory itself
    logic [31:0] ref_mem [DEPTH];  // what the reference model believes it holds
    logic [31:0] exp_rd = '0;      // expected Read_Data

    // Address map: word w lives at bytes BASE+4w .. BASE+4w+3.
    function automatic bit model_in_range(input logic [31:0] a);
        longint off;
        off = longint'(a) - longint'(BASE);
        return (off >= 0) && (off / 4 < DEPTH);
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One access. ack_delay = k acks in the k-th REQ cycle; 0 never acks.
    // On return the DUT is in the IDLE cycle after DONE with the enables
    // still driven, so a following call is a back-to-back request.
    task automatic do_access(input string name, input bit r, input bit w,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input int ack_delay);
        bit ok;
        bit fault;
        bit exp_valid;
        int idx;
        int fz;
        int reqn;
        int exp_fz;

        ok     = model_in_range(addr);
        idx    = ok ? int'((addr - BASE) / 4) : 0;
        fault  = !ok || (ack_delay == 0);
        exp_fz = !ok ? 1 : (ack_delay == 0 ? 1 + TIMEOUT : 1 + ack_delay);

        MEM_R_EN  = r;
        MEM_W_EN  = w;
        Mem_Addr  = addr;
        Wr_Data   = wd;
        Ext_Ack   = 1'b0;
        Ext_Rdata = $urandom;
        #1;
        tests_run++;
        if ({Freeze, Ext_Req, Read_Valid, Err} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL %s issue {Freeze,Req,Valid,Err}: got %b expected 1000",
                     name, {Freeze, Ext_Req, Read_Valid, Err});
        end

        fz   = 1;
        reqn = 0;
        next_cycle();
        while (Freeze === 1'b1 && reqn < 64) begin
            reqn++;
            fz++;
            tests_run++;
            if ({Ext_Req, Ext_We, Ext_Addr} !== {1'b1, w, AW'(idx)}) begin
                tests_failed++;
                $display("FAIL %s req cycle %0d {Req,We,Addr}: got %b/%b/%0d expected 1/%b/%0d",
                         name, reqn, Ext_Req, Ext_We, Ext_Addr, w, idx);
            end
            if (w) begin
                tests_run++;
                if (Ext_Wdata !== wd) begin
                    tests_failed++;
                    $display("FAIL %s Ext_Wdata: got %h expected %h", name, Ext_Wdata, wd);
                end
            end
            if (reqn == ack_delay) begin
                Ext_Ack = 1'b1;
                if (Ext_We) begin
                    ext_mem[Ext_Addr] = Ext_Wdata;
                    Ext_Rdata = $urandom;
                end else begin
                    Ext_Rdata = ext_mem[Ext_Addr];
                end
            end else begin
                Ext_Rdata = $urandom;
            end
            next_cycle();
            Ext_Ack = 1'b0;
        end
        if (reqn >= 64) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s cycle budget: Freeze still high after %0d REQ cycles", name, reqn);
        end

        // Now in DONE.
        if (w) begin
            if (!fault) ref_mem[idx] = wd;
        end else begin
            exp_rd = fault ? 32'd0 : ref_mem[idx];
        end
        exp_valid = !w && !fault;

        tests_run++;
        if ({Freeze, Ext_Req, Read_Valid, Err} !== {2'b00, exp_valid, fault}) begin
            tests_failed++;
            $display("FAIL %s done {Freeze,Req,Valid,Err}: got %b expected %b",
                     name, {Freeze, Ext_Req, Read_Valid, Err}, {2'b00, exp_valid, fault});
        end
        tests_run++;
        if (Read_Data !== exp_rd) begin
            tests_failed++;
            $display("FAIL %s Read_Data: got %h expected %h", name, Read_Data, exp_rd);
        end
        tests_run++;
        if (fz != exp_fz) begin
            tests_failed++;
            $display("FAIL %s freeze length: got %0d expected %0d", name, fz, exp_fz);
        end
        next_cycle();
    endtask

    // One quiet IDLE cycle, optionally with a stray Ext_Ack that must be ignored.
    task automatic idle_cycle(input string name, input bit stray_ack);
        MEM_R_EN  = 1'b0;
        MEM_W_EN  = 1'b0;
        Ext_Ack   = stray_ack;
        Ext_Rdata = $urandom;
        #1;
        tests_run++;
        if ({Freeze, Ext_Req, Read_Valid, Err} !== 4'b0000 || Read_Data !== exp_rd) begin
            tests_failed++;
            $display("FAIL %s idle {Freeze,Req,Valid,Err}=%b Read_Data=%h expected 0000 %h",
                     name, {Freeze, Ext_Req, Read_Valid, Err}, Read_Data, exp_rd);
        end
        next_cycle();
        Ext_Ack = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        MEM_R_EN = 1'b1;
        Mem_Addr = 32'd1032;
        repeat (3) begin
            next_cycle();
            tests_run++;
            if ({Ext_Req, Ext_We, Ext_Addr, Ext_Wdata, Read_Data, Read_Valid, Err} !== '0) begin
                tests_failed++;
                $display("FAIL reset outputs: Req=%b We=%b Addr=%0d Wdata=%h Rd=%h Valid=%b Err=%b expected all 0",
                         Ext_Req, Ext_We, Ext_Addr, Ext_Wdata, Read_Data, Read_Valid, Err);
            end
        end
        MEM_R_EN = 1'b0;
        #1;
        tests_run++;
        if (Freeze !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset Freeze: got %b expected 0", Freeze);
        end
        rst    = 1'b1;
        exp_rd = '0;
        next_cycle();
        idle_cycle("post_reset", 1'b0);
    endtask

    task automatic test_read();
        ext_mem[2] = 32'hCAFE0001;
        ref_mem[2] = 32'hCAFE0001;
        do_access("read_1032", 1'b1, 1'b0, 32'd1032, $urandom, 2);
        idle_cycle("read_after", 1'b0);
    endtask

    task automatic test_write_readback();
        do_access("write_1028", 1'b0, 1'b1, 32'd1028, 32'h12345678, 1);
        idle_cycle("write_after", 1'b0);
        do_access("readback_1028", 1'b1, 1'b0, 32'd1028, $urandom, 3);
        idle_cycle("readback_after", 1'b0);
    endtask

    task automatic test_range();
        do_access("below_base", 1'b1, 1'b0, 32'd1020, $urandom, 1);
        idle_cycle("below_after", 1'b0);
        do_access("past_end", 1'b1, 1'b0, BASE + 32'(4 * DEPTH), $urandom, 1);
        idle_cycle("past_after", 1'b0);
        do_access("last_word", 1'b1, 1'b0, BASE + 32'(4 * DEPTH - 1), $urandom, 1);
        idle_cycle("last_after", 1'b0);
    endtask

    task automatic test_both_enables();
        idle_cycle("stray_ack", 1'b1);
        idle_cycle("stray_ack_check", 1'b0);
        do_access("both_en", 1'b1, 1'b1, 32'd1024, $urandom, 1);
        idle_cycle("both_after", 1'b0);
        do_access("both_readback", 1'b1, 1'b0, 32'd1024, $urandom, 1);
        idle_cycle("both_rb_after", 1'b0);
    endtask

    task automatic test_back_to_back();
        do_access("b2b_w", 1'b0, 1'b1, BASE + 32'd40, $urandom, 1);
        do_access("b2b_r", 1'b1, 1'b0, BASE + 32'd40, $urandom, 1);
        do_access("b2b_oor", 1'b1, 1'b0, 32'd4, $urandom, 1);
        do_access("b2b_r2", 1'b1, 1'b0, BASE + 32'd41, $urandom, 4);
        idle_cycle("b2b_after", 1'b0);
    endtask

    task automatic test_reset_mid_req();
        MEM_R_EN = 1'b1;
        MEM_W_EN = 1'b0;
        Mem_Addr = BASE + 32'd8;
        Ext_Ack  = 1'b0;
        next_cycle();
        tests_run++;
        if (Ext_Req !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_req setup Ext_Req: got %b expected 1", Ext_Req);
        end
        rst = 1'b0;
        next_cycle();
        rst      = 1'b1;
        MEM_R_EN = 1'b0;
        exp_rd   = '0;
        #1;
        tests_run++;
        if ({Ext_Req, Freeze, Read_Data} !== {2'b00, 32'd0}) begin
            tests_failed++;
            $display("FAIL mid_req reset: Req=%b Freeze=%b Rd=%h expected 0 0 0",
                     Ext_Req, Freeze, Read_Data);
        end
        next_cycle();
        idle_cycle("mid_req_after", 1'b0);
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        do_access("timeout_rd", 1'b1, 1'b0, BASE + 32'd12, $urandom, 0);
        idle_cycle("timeout_rd_after", 1'b0);
        do_access("timeout_wr", 1'b0, 1'b1, BASE + 32'd12, $urandom, 0);
        idle_cycle("timeout_wr_after", 1'b0);
        do_access("ack_at_expiry", 1'b1, 1'b0, BASE + 32'd12, $urandom, TIMEOUT);
        idle_cycle("ack_at_expiry_after", 1'b0);
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            int          kind;
            int          op;
            logic [31:0] addr;
            kind = $urandom_range(0, 9);
            if (kind == 0) addr = $urandom_range(0, int'(BASE) - 1);
            else if (kind == 1) addr = BASE + 32'(4 * DEPTH) + $urandom_range(0, 1000);
            else if (kind == 2) addr = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
            op = $urandom_range(0, 2);
            do_access("random", op != 1, op != 0, addr, $urandom, $urandom_range(1, 4));
            if ($urandom_range(0, 2) == 0) idle_cycle("random_gap", 1'($urandom_range(0, 1)));
        end
        idle_cycle("random_end", 1'b0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ext_mem[i] = $urandom;
            ref_mem[i] = ext_mem[i];
        end
        rst       = 1'b0;
        MEM_R_EN  = 1'b0;
        MEM_W_EN  = 1'b0;
        Mem_Addr  = '0;
        Wr_Data   = '0;
        Ext_Ack   = 1'b0;
        Ext_Rdata = '0;

        test_reset();
        test_read();
        test_write_readback();
        test_range();
        test_both_enables();
        test_back_to_back();
        test_reset_mid_req();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Multi-cycle memory access controller between the MEM stage and a slow word-addressed external data memory. It translates pipeline byte addresses to word indices, runs a req/ack handshake with the memory, and raises Freeze to stall the pipeline until the access completes. Read data is registered and presented with a one-cycle valid strobe when Freeze drops.

## Interface
- BASE_ADDR, 32'd1024: byte address mapped to word 0 of external memory
- DEPTH, 64: external memory depth in 32-bit words (power of two)
- TIMEOUT, 16: max REQ cycles without Ext_Ack (used only with MEM_TIMEOUT_EN)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- MEM_R_EN  in  1  load request from MEM stage
- MEM_W_EN  in  1  store request from MEM stage
- Mem_Addr  in  32  byte address (ALU result)
- Wr_Data  in  32  store data (Val_Rm)
- Freeze  out  1  stall pipeline registers upstream of and including MEM/WB
- Read_Data  out  32  registered load data
- Read_Valid  out  1  one-cycle strobe, Read_Data valid
- Err  out  1  one-cycle strobe, access faulted
- Ext_Req  out  1  request to external memory
- Ext_We  out  1  1 = write, 0 = read
- Ext_Addr  out  log2(DEPTH)  word index
- Ext_Wdata  out  32  write data
- Ext_Ack  in  1  memory completion, single cycle
- Ext_Rdata  in  32  read data, valid with Ext_Ack

## Operation
- States: IDLE, REQ, DONE.
- Word index = (Mem_Addr - BASE_ADDR) >> 2, 32-bit unsigned subtraction; bits [1:0] ignored.
- In range iff Mem_Addr >= BASE_ADDR and index < DEPTH.
- IDLE: if MEM_R_EN or MEM_W_EN, Freeze=1 (combinational); latch index, Wr_Data, and write flag (MEM_W_EN wins if both are set). In range -> REQ; out of range -> DONE with fault pending.
- REQ: Ext_Req=1; Ext_We/Ext_Addr/Ext_Wdata held from latched values; Freeze=1. On Ext_Ack: capture Ext_Rdata into Read_Data (reads only) -> DONE.
- DONE: Freeze=0, Ext_Req=0; Read_Valid=1 for reads without fault; Err=1 on fault, with Read_Data forced to 0 on a faulted read -> IDLE.
- Writes leave Read_Data unchanged; Read_Valid stays 0 for writes.
- Ext_Ack while not in REQ is ignored.
- Both enables set: handled as write; Err is not raised.

## Timing
- Reset (rst=0 at edge): state IDLE; Freeze=0 (outside a request), Ext_Req=0, Ext_We=0, Ext_Addr=0, Ext_Wdata=0, Read_Data=0, Read_Valid=0, Err=0.
- Reset wins over everything, including an in-flight REQ; Ext_Req drops on the next cycle.
- Ext_Req, Ext_We, Ext_Addr, Ext_Wdata, Read_Data, Read_Valid, and Err are registered or state-decoded. Freeze is combinational from state and the enables.
- Minimum access takes 3 cycles: cycle 0 IDLE (request seen, Freeze=1), cycle 1 REQ with Ext_Ack=1, cycle 2 DONE (Freeze=0). The pipeline advances at the end of cycle 2.
- Each additional cycle without Ext_Ack adds one Freeze cycle.
- Out-of-range access: IDLE -> DONE, 2 cycles, Ext_Req never asserted.
- Back-to-back accesses: the next request is seen in the IDLE cycle following DONE.

## Configuration
- MEM_TIMEOUT_EN defined: a counter runs in REQ. If TIMEOUT cycles elapse without Ext_Ack, drop Ext_Req and go to DONE with a fault (Err=1, Read_Data=0 for reads). An Ext_Ack arriving in the same cycle as expiry counts as success.
- MEM_TIMEOUT_EN undefined: no counter; REQ waits indefinitely for Ext_Ack.

## Test plan
- Reset: hold rst=0 for 3 cycles with MEM_R_EN=1 -> all outputs 0, Ext_Req stays 0.
- Read: Mem_Addr=1032, MEM_R_EN=1, Ext_Ack after 2 REQ cycles with Ext_Rdata=32'hCAFE0001 -> Ext_Addr=2, Freeze high 3 cycles, Read_Valid=1 with Read_Data=32'hCAFE0001 in DONE.
- Write then read back: write 32'h12345678 to 1028, then read 1028 (memory model) -> Ext_We=1, Ext_Addr=1, Read_Valid=0 on the write; the read returns 32'h12345678.
- Range: Mem_Addr=1020 and Mem_Addr=1024+4*64 reads -> no Ext_Req, Err=1, Read_Data=0, Freeze for exactly 1 cycle.
- Both enables with Mem_Addr=1024 -> write issued (Ext_We=1), Err=0; Ext_Ack in IDLE ignored.
- Timeout (MEM_TIMEOUT_EN, TIMEOUT=16): no Ext_Ack -> Ext_Req high 16 cycles, then Err=1, Freeze drops. Separately, rst=0 mid-REQ -> Ext_Req=0 next cycle.
